if_id_stage: RTL and testbench

- Parametrised IF->ID pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Sits between instruction fetch and decode.
- Supports stall (backpressure from ID), flush (branch/exception redirect) and NOP bubble insertion.
- Provides a saturating stall-cycle counter for performance debug.

---
 rtl/if_id_stage.sv | 116 +++++++++++
 tb/tb_if_id_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF->ID pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush and a saturating stall-cycle counter.
module if_id_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // in_ready comes from registered state only, so no out_ready->in_ready path.
  assign in_ready  = (state_q != StSkid);
  assign out_valid = (state_q != StEmpty);
  assign id_pc     = main_pc_q;
  assign id_inst   = main_inst_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    stall_cnt_d = stall_cnt_q;

    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StEmpty: begin
        if (in_valid) begin
          main_pc_d   = if_pc;
          main_inst_d = if_inst;
          state_d     = StFull;
        end
      end
      StFull: begin
        if (out_ready) begin
          if (in_valid) begin
            main_pc_d   = if_pc;
            main_inst_d = if_inst;
          end else begin
            // Going empty: show a bubble but keep the last PC visible.
            main_inst_d = NOP_INST;
            state_d     = StEmpty;
          end
        end else if (in_valid) begin
          skid_pc_d   = if_pc;
          skid_inst_d = if_inst;
          state_d     = StSkid;
        end
      end
      StSkid: begin
        if (out_ready) begin
          main_pc_d   = skid_pc_q;
          main_inst_d = skid_inst_q;
          state_d     = StFull;
        end
      end
      default: begin
        main_inst_d = NOP_INST;
        state_d     = StEmpty;
      end
    endcase

    // Flush drops held and incoming instructions; the stall counter keeps running.
    if (flush) begin
      state_d     = StEmpty;
      main_pc_d   = '0;
      main_inst_d = NOP_INST;
      skid_pc_d   = '0;
      skid_inst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_if_id_stage;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [ADDR_W-1:0] if_pc, id_pc;
  logic [INST_W-1:0] if_inst, id_inst;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  if_id_stage #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two instructions.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } item_t;

  item_t             mq[$];
  logic [ADDR_W-1:0] m_held_pc = '0;
  int                m_cnt = 0;
  bit                m_ok = 1'b0;

  // Checks the state left by the last edge, then advances the model with the
  // inputs that the next edge will sample (inputs change only just after posedge).
  always @(negedge clk) begin
    if (m_ok) begin
      check("cmp_in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check("cmp_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("cmp_id_pc", 64'(id_pc), 64'((mq.size() > 0) ? mq[0].pc : m_held_pc));
      check("cmp_id_inst", 64'(id_inst), 64'((mq.size() > 0) ? mq[0].inst : NOP));
      check("cmp_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    end
    if (rst) begin
      mq.delete();
      m_held_pc = '0;
      m_cnt     = 0;
      m_ok      = 1'b1;
    end else if (m_ok) begin
      if (mq.size() > 0 && !out_ready && m_cnt < int'(CNT_MAX)) m_cnt++;
      if (flush) begin
        mq.delete();
        m_held_pc = '0;
      end else begin
        bit can_take;
        can_take = (mq.size() < 2);
        if (mq.size() > 0 && out_ready) begin
          m_held_pc = mq[0].pc;
          void'(mq.pop_front());
        end
        if (in_valid && can_take) mq.push_back('{pc: if_pc, inst: if_inst});
      end
    end
  end

  function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Apply inputs, then return 1 time unit after the sampling edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [ADDR_W-1:0] pc, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    if_pc     = pc;
    if_inst   = inst_of(pc);
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if_pc = '0; if_inst = '0;

    // Reset then stream
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_id_pc", 64'(id_pc), 64'd0);
    check("rst_id_inst", 64'(id_inst), 64'(NOP));
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    step(0, 0, 1, 32'h00, 1);
    check("stream_valid0", 64'(out_valid), 64'd1);
    check("stream_pc0", 64'(id_pc), 64'h00);
    check("stream_inst0", 64'(id_inst), 64'hA5A5_0000);
    step(0, 0, 1, 32'h04, 1);
    check("stream_pc1", 64'(id_pc), 64'h04);
    step(0, 0, 1, 32'h08, 1);
    check("stream_pc2", 64'(id_pc), 64'h08);
    step(0, 0, 0, 0, 1);
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_inst_nop", 64'(id_inst), 64'(NOP));
    check("drain_pc_held", 64'(id_pc), 64'h08);

    // Backpressure into skid
    step(0, 0, 1, 32'h10, 1);
    step(0, 0, 1, 32'h14, 0);
    check("skid_in_ready", 64'(in_ready), 64'd0);
    check("skid_pc_main", 64'(id_pc), 64'h10);
    step(0, 0, 0, 0, 0);
    check("skid_stable_pc", 64'(id_pc), 64'h10);
    step(0, 0, 0, 0, 1);
    check("skid_pc_second", 64'(id_pc), 64'h14);
    check("skid_in_ready_back", 64'(in_ready), 64'd1);
    check("skid_stall_cnt", 64'(stall_cnt), 64'd2);
    step(0, 0, 0, 0, 1);
    check("skid_drained", 64'(out_valid), 64'd0);

    // Long stall saturation
    step(0, 0, 1, 32'h40, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    check("sat_stall_cnt", 64'(stall_cnt), 64'(CNT_MAX));
    check("sat_pc_stable", 64'(id_pc), 64'h40);
    step(0, 0, 0, 0, 1);

    // Flush in SKID
    step(0, 0, 1, 32'h20, 1);
    step(0, 0, 1, 32'h24, 0);
    step(0, 1, 1, 32'h28, 0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_inst_nop", 64'(id_inst), 64'(NOP));
    check("flush_pc_zero", 64'(id_pc), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_keeps_cnt", 64'(stall_cnt), 64'(CNT_MAX));
    step(0, 0, 0, 0, 1);
    check("flush_nothing_left", 64'(out_valid), 64'd0);

    // Reset overrides flush in FULL
    step(0, 0, 1, 32'h30, 0);
    step(1, 1, 0, 0, 0);
    check("rstflush_valid", 64'(out_valid), 64'd0);
    check("rstflush_pc", 64'(id_pc), 64'd0);
    check("rstflush_inst", 64'(id_inst), 64'(NOP));
    check("rstflush_cnt", 64'(stall_cnt), 64'd0);
    check("rstflush_in_ready", 64'(in_ready), 64'd1);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 10000; i++) begin
      step(0, ($urandom_range(63) == 0), 1'($urandom_range(1)), 32'(32'h1000 + 4 * i),
           ($urandom_range(3) != 0) ? 1'($urandom_range(1)) : 1'b0);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
